// File: rtl/conv_coeff_loader.sv
// 3x3 convolution coefficient loader: host-written shadow bank, vsync-safe swap
// into an active bank that is streamed one coefficient per cycle while vs_i is high.
module conv_coeff_loader #(
  parameter int COEFF_W = 9,
  parameter int N_COEFF = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en_i,
  input  logic [3:0]         wr_addr_i,
  input  logic [COEFF_W-1:0] wr_data_i,
  input  logic               commit_i,
  input  logic               vs_i,
  output logic [COEFF_W-1:0] coeff_o,
  output logic               pending_o,
  output logic               load_done_o,
  output logic               err_o
);

  typedef enum logic [1:0] {IDLE, STREAM, HOLD} state_e;
  typedef logic [N_COEFF-1:0][COEFF_W-1:0] bank_t;

  localparam logic [3:0] N_IDX = 4'(N_COEFF);

  function automatic bank_t ident_bank();
    bank_t b;
    b = '0;
    b[N_COEFF/2] = COEFF_W'(1);
    return b;
  endfunction

  localparam bank_t IDENT = ident_bank();

  // Assert asynchronously, release two edges after rst rises.
  logic [1:0] rsync_q, rsync_d;
  logic       rst_n;

  assign rsync_d = {rsync_q[0], 1'b1};
  assign rst_n   = rsync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rsync_q <= '0;
    else      rsync_q <= rsync_d;
  end

  bank_t      shadow_q, shadow_d, active_q, active_d;
  logic       pending_q, pending_d;
  logic       err_q, err_d;
  logic       done_q, done_d;
  logic [3:0] idx_q, idx_d;
  state_e     state_q, state_d;
  logic       swap;

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    swap      = pending_q && !vs_i;
    // Swap copies the pre-write shadow; a same-edge write lands in shadow only.
    if (swap) active_d = shadow_q;
    if (wr_en_i && (wr_addr_i < N_IDX)) shadow_d[wr_addr_i] = wr_data_i;
    err_d = wr_en_i && (wr_addr_i >= N_IDX);
    if (swap)          pending_d = 1'b0;
    else if (commit_i) pending_d = 1'b1;

    if (!vs_i)              idx_d = '0;
    else if (idx_q < N_IDX) idx_d = idx_q + 4'd1;
    else                    idx_d = idx_q;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:   if (vs_i) state_d = STREAM;
      STREAM: begin
        if (!vs_i) state_d = IDLE;
        else if (idx_d == N_IDX) begin
          state_d = HOLD;
          done_d  = 1'b1;
        end
      end
      HOLD:   if (!vs_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= IDENT;
      active_q  <= IDENT;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= '0;
      state_q   <= IDLE;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      done_q    <= done_d;
      idx_q     <= idx_d;
      state_q   <= state_d;
    end
  end

  assign coeff_o     = (rst_n && vs_i && (idx_q < N_IDX)) ? active_q[idx_q] : '0;
  assign pending_o   = pending_q;
  assign load_done_o = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_conv_coeff_loader.sv
// Bench for conv_coeff_loader: per-cycle compare against a frame-position model
// plus literal expectations for the directed scenarios.
module tb_conv_coeff_loader;
  logic       clk, rst, wr_en_i, commit_i, vs_i;
  logic [3:0] wr_addr_i;
  logic [8:0] wr_data_i, coeff_o;
  logic       pending_o, load_done_o, err_o;

  int n_total = 0, n_pass = 0;

  conv_coeff_loader #(.COEFF_W(9), .N_COEFF(9)) dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .commit_i(commit_i), .vs_i(vs_i),
    .coeff_o(coeff_o), .pending_o(pending_o), .load_done_o(load_done_o),
    .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: banks as plain arrays, position = edges since vs rose (capped at 9).
  logic [8:0] m_sh[9], m_ac[9], old_sh[9];
  int  m_pos, m_sync;
  bit  m_pend, m_err, m_done, started;

  function automatic void mreset();
    for (int i = 0; i < 9; i++) begin
      m_sh[i] = (i == 4) ? 9'd1 : 9'd0;
      m_ac[i] = m_sh[i];
    end
    m_pos = 0; m_sync = 0; m_pend = 0; m_err = 0; m_done = 0;
  endfunction

  always @(negedge rst) mreset();

  always @(posedge clk) begin
    started = 1;
    if (!rst) mreset();
    else if (m_sync < 2) begin
      m_sync++;
      m_err = 0; m_done = 0;
    end else begin
      old_sh = m_sh;
      m_err  = wr_en_i && (wr_addr_i >= 9);
      m_done = vs_i && (m_pos == 8);
      if (wr_en_i && wr_addr_i < 9) m_sh[wr_addr_i] = wr_data_i;
      if (m_pend && !vs_i) begin
        m_ac = old_sh;
        m_pend = 0;
      end else if (commit_i) m_pend = 1;
      m_pos = vs_i ? ((m_pos < 9) ? m_pos + 1 : 9) : 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [8:0] ec;
      ec = (rst && m_sync == 2 && vs_i && m_pos < 9) ? m_ac[m_pos] : 9'd0;
      chk("coeff_o", int'(coeff_o), int'(ec));
      chk("pending_o", int'(pending_o), int'(m_pend));
      chk("load_done_o", int'(load_done_o), int'(m_done));
      chk("err_o", int'(err_o), int'(m_err));
    end
  end

  logic [8:0] cap[16];
  bit         dcap[16];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [8:0] d);
    wr_en_i = 1; wr_addr_i = a; wr_data_i = d;
    step(1);
    wr_en_i = 0;
  endtask

  task automatic frame(input int n, input int commit_at);
    vs_i = 1;
    for (int i = 0; i < n; i++) begin
      commit_i = (i == commit_at);
      @(negedge clk);
      cap[i] = coeff_o;
      dcap[i] = load_done_o;
      step(1);
    end
    commit_i = 0;
  endtask

  task automatic chk_done(input string nm, input int n);
    for (int i = 0; i < n; i++) chk(nm, int'(dcap[i]), (n >= 10 && i == 9) ? 1 : 0);
  endtask

  initial begin
    rst = 0; wr_en_i = 0; commit_i = 0; vs_i = 0; wr_addr_i = 0; wr_data_i = 0;
    step(3);
    vs_i = 1;
    @(negedge clk);
    chk("reset_coeff", int'(coeff_o), 0);
    chk("reset_pending", int'(pending_o), 0);
    step(1);
    vs_i = 0;
    rst = 1;
    step(4);

    // Identity kernel after reset
    frame(12, -1); vs_i = 0;
    for (int i = 0; i < 12; i++) chk("ident_frame", int'(cap[i]), (i == 4) ? 1 : 0);
    chk_done("ident_done", 12);
    step(2);

    // Load 1..9, commit while idle
    for (int k = 0; k < 9; k++) wr(4'(k), 9'(k + 1));
    commit_i = 1; step(1); commit_i = 0;
    chk("commit_pending_set", int'(pending_o), 1);
    step(1);
    chk("commit_pending_clr", int'(pending_o), 0);
    frame(11, -1); vs_i = 0;
    for (int i = 0; i < 11; i++) chk("seq_frame", int'(cap[i]), (i < 9) ? i + 1 : 0);
    chk_done("seq_done", 11);
    step(2);

    // Commit mid-frame: old bank streams, swap on vs fall with same-edge write+commit
    for (int k = 0; k < 9; k++) wr(4'(k), 9'h100 + 9'(k));
    frame(11, 3);
    for (int i = 0; i < 11; i++) chk("old_bank_frame", int'(cap[i]), (i < 9) ? i + 1 : 0);
    chk("pending_held", int'(pending_o), 1);
    vs_i = 0; wr_en_i = 1; wr_addr_i = 0; wr_data_i = 9'h055; commit_i = 1;
    step(1);
    wr_en_i = 0; commit_i = 0;
    chk("swap_absorbs_commit", int'(pending_o), 0);
    step(1);
    frame(10, -1); vs_i = 0;
    for (int i = 0; i < 10; i++)
      chk("new_bank_frame", int'(cap[i]), (i < 9) ? 'h100 + i : 0);
    step(2);

    // Out-of-range write
    wr(4'd9, 9'h1FF);
    chk("err_pulse", int'(err_o), 1);
    step(1);
    chk("err_clear", int'(err_o), 0);
    frame(10, -1); vs_i = 0;
    for (int i = 0; i < 10; i++)
      chk("post_err_frame", int'(cap[i]), (i < 9) ? 'h100 + i : 0);
    step(2);

    // Short sync then full frame restart
    frame(5, -1); vs_i = 0;
    for (int i = 0; i < 5; i++) chk("short_frame", int'(cap[i]), 'h100 + i);
    chk_done("short_done", 5);
    step(1);
    frame(10, -1); vs_i = 0;
    chk("restart_idx0", int'(cap[0]), 'h100);
    chk_done("restart_done", 10);
    step(2);

    // Async reset mid-stream at index 3
    vs_i = 1;
    step(3);
    @(negedge clk);
    chk("pre_reset_idx3", int'(coeff_o), 'h103);
    #2 rst = 0;
    #1 chk("async_reset_coeff", int'(coeff_o), 0);
    vs_i = 0;
    step(3);
    rst = 1;
    step(4);
    frame(12, -1); vs_i = 0;
    for (int i = 0; i < 12; i++) chk("post_reset_ident", int'(cap[i]), (i == 4) ? 1 : 0);
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/conv_coeff_loader.md
CONV_COEFF_LOADER -- requirements
Module: conv_coeff_loader

Interface
REQ-001 Parameter COEFF_W, default 9: width of one kernel coefficient.
REQ-002 Parameter N_COEFF, default 9: number of coefficients in the 3x3 kernel.
REQ-003 clk  in  1  single system clock; all logic on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-005 wr_en_i  in  1  host write strobe, one coefficient per cycle.
REQ-006 wr_addr_i  in  4  host coefficient index, 0..N_COEFF-1.
REQ-007 wr_data_i  in  COEFF_W  host coefficient value, two's complement.
REQ-008 commit_i  in  1  single-cycle pulse: request shadow bank -> active bank transfer.
REQ-009 vs_i  in  1  vertical sync from the video timing; the same signal drives the convolution core.
REQ-010 coeff_o  out  COEFF_W  coefficient stream to the convolution core's coeff_i.
REQ-011 pending_o  out  1  commit accepted, swap not yet done.
REQ-012 load_done_o  out  1  one-cycle pulse after the last coefficient of a frame has been presented.
REQ-013 err_o  out  1  one-cycle pulse on an out-of-range write address.

Function
REQ-014 The block SHALL hold two banks of N_COEFF x COEFF_W registers: shadow (host-written) and active (streamed).
REQ-015 wr_en_i=1 with wr_addr_i<N_COEFF SHALL write wr_data_i into shadow[wr_addr_i] on that edge.
REQ-016 wr_en_i=1 with wr_addr_i>=N_COEFF SHALL leave both banks unchanged and assert err_o on the next cycle for exactly one cycle.
REQ-017 commit_i=1 SHALL set pending_o on the next edge; a commit while pending_o=1 SHALL have no further effect.
REQ-018 Swap: on any edge where pending_o=1 and vs_i=0, the active bank SHALL load the entire shadow bank and pending_o SHALL clear.
REQ-019 The swap SHALL never occur while vs_i=1, so that the active bank stays constant during streaming.
REQ-020 A simultaneous wr_en_i and swap SHALL copy the pre-write shadow value into the active bank; the write lands in shadow only.
REQ-021 A simultaneous commit_i and swap edge SHALL leave pending_o=0, because the commit is absorbed by that swap.
REQ-022 Stream index idx (4 bits) SHALL be cleared on every edge where vs_i=0.
REQ-023 On every edge where vs_i=1, idx SHALL increment and saturate at N_COEFF.
REQ-024 coeff_o SHALL be combinational from registers: active[idx] when vs_i=1 and idx<N_COEFF, otherwise 0.
REQ-025 coeff_o therefore SHALL present active[0] in the first cycle vs_i is high and active[k] in the k-th following cycle, with zero added latency.
REQ-026 FSM states:
- IDLE (vs_i=0)
- STREAM (vs_i=1, idx<N_COEFF)
- HOLD (vs_i=1, idx=N_COEFF)
REQ-027 FSM transitions:
- IDLE->STREAM on vs_i=1
- STREAM->HOLD when idx reaches N_COEFF
- STREAM or HOLD -> IDLE when vs_i=0
REQ-028 load_done_o SHALL pulse for one cycle on the STREAM->HOLD transition, once per frame.
REQ-029 If vs_i falls while in STREAM (short sync), the FSM SHALL return to IDLE, idx SHALL clear, and load_done_o SHALL NOT pulse.
REQ-030 Every vs_i-high period SHALL re-stream the full active bank, whether or not a swap occurred.

Reset
REQ-031 While rst=0, shadow and active SHALL both hold the identity kernel: index 4 = 1, all others 0.
REQ-032 While rst=0: idx=0, FSM=IDLE, pending_o=0, load_done_o=0, err_o=0, and coeff_o=0.
REQ-033 Reset asserted mid-STREAM SHALL take effect immediately and asynchronously; coeff_o SHALL drop to 0 without waiting for a clock edge.
REQ-034 Release of rst SHALL be synchronized internally so the first active edge is glitch-free.

Verification
REQ-035 Reset, then vs_i high for 12 cycles -> coeff_o = 0,0,0,0,1,0,0,0,0, then 0,0,0; load_done_o pulses once, on the cycle after coeff index 8.
REQ-036 Write shadow[k]=k+1 for k=0..8, commit with vs_i=0 -> pending_o=1 for one cycle then 0; next vs_i-high period streams 1..9.
REQ-037 Commit while vs_i=1 -> pending_o stays 1 and the current frame streams the old bank; swap happens on the first vs_i=0 edge; the next frame streams the new bank.
REQ-038 wr_en_i with wr_addr_i=9 and data 9'h1FF -> err_o pulses one cycle; no coefficient changes in the next streamed frame.
REQ-039 vs_i high for only 5 cycles -> coeff_o streams indices 0..4, no load_done_o; the next full vs_i-high period restarts at index 0.
REQ-040 rst=0 asserted at stream index 3 -> coeff_o=0 asynchronously; after release, both banks hold the identity kernel.
